// File: rtl/struct_field_packer_if.sv
// Field-write and packed-word output bundle for struct_field_packer.
// The block under design takes the slave modport; producer/consumer take master.
interface struct_field_packer_if #(
  parameter int NUM_FIELDS = 4,
  parameter int FIELD_W    = 1,
  parameter int IDX_W      = 2
);
  logic                          fld_valid;
  logic                          fld_ready;
  logic [IDX_W-1:0]              fld_idx;
  logic [FIELD_W-1:0]            fld_data;
  logic                          flush;
  logic                          out_valid;
  logic                          out_ready;
  logic [NUM_FIELDS*FIELD_W-1:0] out_data;
  logic                          out_partial;
  logic                          err_idx;

  modport slave (
    input  fld_valid, fld_idx, fld_data, flush, out_ready,
    output fld_ready, out_valid, out_data, out_partial, err_idx
  );

  modport master (
    output fld_valid, fld_idx, fld_data, flush, out_ready,
    input  fld_ready, out_valid, out_data, out_partial, err_idx
  );
endinterface

// File: rtl/struct_field_packer.sv
// Collects indexed field writes into a packed struct word (field 0 in the MSBs)
// and presents the whole word on a valid/ready port once complete or flushed.
module struct_field_packer #(
  parameter int                            NUM_FIELDS = 4,
  parameter int                            FIELD_W    = 1,
  parameter int                            IDX_W      = 2,
  parameter logic [NUM_FIELDS*FIELD_W-1:0] DEFAULT    = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  struct_field_packer_if.slave   bus
);
  localparam int W = NUM_FIELDS * FIELD_W;

  typedef enum logic {FILL, HOLD} state_t;

  state_t                r_state;
  logic [NUM_FIELDS-1:0] r_mask;
  logic [W-1:0]          r_data;
  logic                  r_fld_ready;
  logic                  r_out_valid;
  logic                  r_out_partial;
  logic                  r_err_idx;

  logic                  w_wr_ok;
  logic                  w_in_range;
  logic [NUM_FIELDS-1:0] w_mask_set;
  logic [NUM_FIELDS-1:0] w_mask_next;
  logic [W-1:0]          w_data_next;
  logic                  w_done;

  // r_fld_ready is only high in FILL, so it also gates writes away from HOLD.
  assign w_wr_ok     = bus.fld_valid & r_fld_ready;
  assign w_in_range  = (32'(bus.fld_idx) < NUM_FIELDS);
  assign w_mask_next = r_mask | w_mask_set;
  assign w_done      = (&w_mask_next) | bus.flush;

  for (genvar k = 0; k < NUM_FIELDS; k++) begin : g_field
    assign w_mask_set[k] = w_wr_ok & w_in_range & (32'(bus.fld_idx) == k);
    assign w_data_next[(NUM_FIELDS-k)*FIELD_W-1 -: FIELD_W] =
      w_mask_set[k] ? bus.fld_data : r_data[(NUM_FIELDS-k)*FIELD_W-1 -: FIELD_W];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= FILL;
      r_mask        <= '0;
      r_data        <= DEFAULT;
      r_fld_ready   <= 1'b1;
      r_out_valid   <= 1'b0;
      r_out_partial <= 1'b0;
      r_err_idx     <= 1'b0;
    end else begin
      case (r_state)
        FILL: begin
          r_mask <= w_mask_next;
          r_data <= w_data_next;
          if (w_wr_ok && !w_in_range) r_err_idx <= 1'b1;
          if (w_done) begin
            r_state       <= HOLD;
            r_fld_ready   <= 1'b0;
            r_out_valid   <= 1'b1;
            r_out_partial <= ~&w_mask_next;
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            r_state       <= FILL;
            r_mask        <= '0;
            r_data        <= DEFAULT;
            r_fld_ready   <= 1'b1;
            r_out_valid   <= 1'b0;
            r_out_partial <= 1'b0;
          end
        end
        default: r_state <= FILL;
      endcase
    end
  end

  assign bus.fld_ready   = r_fld_ready;
  assign bus.out_valid   = r_out_valid;
  assign bus.out_data    = r_data;
  assign bus.out_partial = r_out_partial;
  assign bus.err_idx     = r_err_idx;
endmodule

// File: tb/tb_struct_field_packer.sv
// Directed bench for struct_field_packer: 4 one-bit fields, 3-bit index,
// DEFAULT = 4'b0011 so unwritten fields are visible in the output word.
module tb_struct_field_packer;
  logic gclk = 1'b0;
  logic rst;
  int   ncmp  = 0;
  int   nfail = 0;

  always #5 gclk = ~gclk;

  struct_field_packer_if #(.NUM_FIELDS(4), .FIELD_W(1), .IDX_W(3)) bus ();

  struct_field_packer #(
    .NUM_FIELDS(4), .FIELD_W(1), .IDX_W(3), .DEFAULT(4'b0011)
  ) dut (
    .clk (gclk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick();
    @(posedge gclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [2:0] idx, input logic d);
    bus.fld_valid = 1'b1;
    bus.fld_idx   = idx;
    bus.fld_data  = d;
    tick();
    bus.fld_valid = 1'b0;
  endtask

  task automatic accept();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  initial begin
    rst           = 1'b1;
    bus.fld_valid = 1'b0;
    bus.fld_idx   = '0;
    bus.fld_data  = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    tick(); tick();
    chk("rst_fld_ready", 32'(bus.fld_ready), 1);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_out_data", 32'(bus.out_data), 32'b0011);
    chk("rst_partial", 32'(bus.out_partial), 0);
    chk("rst_err", 32'(bus.err_idx), 0);
    rst = 1'b0;

    // in-order writes on consecutive cycles
    wr(0, 1); wr(1, 1); wr(2, 0);
    chk("inorder_not_yet", 32'(bus.out_valid), 0);
    wr(3, 0);
    chk("inorder_valid", 32'(bus.out_valid), 1);
    chk("inorder_data", 32'(bus.out_data), 32'b1100);
    chk("inorder_partial", 32'(bus.out_partial), 0);
    chk("inorder_fld_ready", 32'(bus.fld_ready), 0);
    accept();
    chk("hs_valid_low", 32'(bus.out_valid), 0);
    chk("hs_fld_ready", 32'(bus.fld_ready), 1);
    chk("hs_data_default", 32'(bus.out_data), 32'b0011);

    // out-of-order writes
    wr(3, 0); wr(0, 1); wr(2, 0); wr(1, 1);
    chk("ooo_valid", 32'(bus.out_valid), 1);
    chk("ooo_data", 32'(bus.out_data), 32'b1100);
    accept();

    // rewrite of field 0 before completion: last write wins
    wr(0, 1); wr(1, 1); wr(0, 0);
    chk("rewrite_not_yet", 32'(bus.out_valid), 0);
    wr(2, 0); wr(3, 0);
    chk("rewrite_valid", 32'(bus.out_valid), 1);
    chk("rewrite_data", 32'(bus.out_data), 32'b0100);
    chk("rewrite_partial", 32'(bus.out_partial), 0);
    accept();

    // flush after one write
    wr(0, 1);
    bus.flush = 1'b1; tick(); bus.flush = 1'b0;
    chk("flush1_valid", 32'(bus.out_valid), 1);
    chk("flush1_data", 32'(bus.out_data), 32'b1011);
    chk("flush1_partial", 32'(bus.out_partial), 1);
    accept();
    chk("flush1_partial_clr", 32'(bus.out_partial), 0);

    // flush with nothing written
    bus.flush = 1'b1; tick(); bus.flush = 1'b0;
    chk("flush0_data", 32'(bus.out_data), 32'b0011);
    chk("flush0_partial", 32'(bus.out_partial), 1);
    accept();

    // flush coincident with a write includes that write
    bus.flush = 1'b1; wr(1, 1); bus.flush = 1'b0;
    chk("flushwr_valid", 32'(bus.out_valid), 1);
    chk("flushwr_data", 32'(bus.out_data), 32'b0111);
    chk("flushwr_partial", 32'(bus.out_partial), 1);
    accept();

    // back-pressure: HOLD ignores writes and flush
    wr(0, 1); wr(1, 0); wr(2, 1); wr(3, 0);
    for (int i = 0; i < 5; i++) begin
      bus.fld_valid = i[0];
      bus.flush     = ~i[0];
      bus.fld_idx   = 3'd3;
      bus.fld_data  = 1'b1;
      tick();
      chk($sformatf("bp_fld_ready_%0d", i), 32'(bus.fld_ready), 0);
      chk($sformatf("bp_valid_%0d", i), 32'(bus.out_valid), 1);
      chk($sformatf("bp_data_%0d", i), 32'(bus.out_data), 32'b1010);
    end
    bus.flush     = 1'b0;
    bus.fld_valid = 1'b1;
    accept();
    bus.fld_valid = 1'b0;
    chk("bp_hs_valid", 32'(bus.out_valid), 0);
    wr(0, 0); wr(1, 0); wr(2, 0);
    chk("bp_mask_cleared", 32'(bus.out_valid), 0);
    bus.flush = 1'b1; tick(); bus.flush = 1'b0;
    chk("bp_next_data", 32'(bus.out_data), 32'b0001);
    chk("bp_next_partial", 32'(bus.out_partial), 1);
    accept();

    // out-of-range index
    wr(5, 0);
    chk("oor_err", 32'(bus.err_idx), 1);
    chk("oor_no_emit", 32'(bus.out_valid), 0);
    chk("oor_fld_ready", 32'(bus.fld_ready), 1);
    wr(0, 0); wr(1, 1); wr(2, 1); wr(3, 0);
    chk("oor_word", 32'(bus.out_data), 32'b0110);
    chk("oor_partial", 32'(bus.out_partial), 0);
    accept();
    chk("oor_err_sticky", 32'(bus.err_idx), 1);

    // reset mid-word
    wr(0, 1); wr(1, 1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("midrst_valid", 32'(bus.out_valid), 0);
    chk("midrst_data", 32'(bus.out_data), 32'b0011);
    chk("midrst_err", 32'(bus.err_idx), 0);
    wr(2, 0); wr(3, 0);
    chk("midrst_no_stale", 32'(bus.out_valid), 0);
    wr(0, 0); wr(1, 1);
    chk("midrst_valid2", 32'(bus.out_valid), 1);
    chk("midrst_data2", 32'(bus.out_data), 32'b0100);
    accept();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
